// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and its byte receiver.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write bus plus loader status, as seen by the memory/CPU side.
interface uart_program_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              frame_error;

    modport master (
        output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, frame_error
    );

    modport slave (
        input imem_we, imem_addr, imem_wdata, cpu_hold, load_done, frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error strobes.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       rx_error
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line back high at mid start bit was a glitch, not a start.
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    err_d   = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign rx_error   = err_q;

endmodule

// File: rtl/uart_program_loader.sv
// Receives a length-prefixed program image over UART and writes it word by word into imem.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_error
);

    localparam logic [16:0] MAX_WORDS = 17'(32'd1 << ADDR_W);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_error;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .rx_error  (rx_error)
    );

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fe_q, fe_d;
    logic [15:0]       len_n;

    assign len_n = {byte_data, len_q[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fe_q       <= fe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fe_d       = 1'b0;
        if (rx_error) begin
            fe_d = 1'b1;
            if (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA) begin
                state_d    = IDLE;
                byte_cnt_d = '0;
                word_d     = '0;
            end
        end else if (byte_valid) begin
            case (state_q)
                IDLE, DONE: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d    = LEN_LO;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                    end
                end
                LEN_LO: begin
                    len_d   = {8'h00, byte_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d      = len_n;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    if (len_n == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_n} > MAX_WORDS) begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = word_idx_q[ADDR_W-1:0];
                            wdata_d = {byte_data, word_q};
                            if (word_idx_q == len_q - 16'd1) begin
                                state_d = DONE;
                            end else begin
                                word_idx_d = word_idx_q + 16'd1;
                            end
                        end
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign frame_error = fe_q;
    assign cpu_hold    = (state_q != DONE);
    assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: serial frames in, imem writes and status checked.
module tb_uart_program_loader;
    import loader_pkg::*;

    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    uart_program_loader_if #(.ADDR_W(AW)) bus ();

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata),
        .cpu_hold   (bus.cpu_hold),
        .load_done  (bus.load_done),
        .frame_error(bus.frame_error)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    int bv_cnt = 0;
    logic [31:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    logic [7:0]  seq [$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = 32'(bus.imem_addr);
                wr_data[wr_cnt] = bus.imem_wdata;
            end
            wr_cnt++;
        end
        if (bus.frame_error) fe_cnt++;
        if (dut.u_rx.byte_valid) bv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0;
        fe_cnt = 0;
        bv_cnt = 0;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_we",    32'(bus.imem_we),     32'd0);
        check_eq("rst_addr",  32'(bus.imem_addr),   32'd0);
        check_eq("rst_wdata", bus.imem_wdata,       32'd0);
        check_eq("rst_hold",  32'(bus.cpu_hold),    32'd1);
        check_eq("rst_done",  32'(bus.load_done),   32'd0);
        check_eq("rst_fe",    32'(bus.frame_error), 32'd0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Two-word image
        clear_counts();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(seq);
        check_eq("two_wr_cnt", 32'(wr_cnt), 32'd2);
        check_eq("two_addr0",  wr_addr[0], 32'd0);
        check_eq("two_data0",  wr_data[0], 32'h0000_0013);
        check_eq("two_addr1",  wr_addr[1], 32'd1);
        check_eq("two_data1",  wr_data[1], 32'h0010_0093);
        check_eq("two_done",   32'(bus.load_done), 32'd1);
        check_eq("two_hold",   32'(bus.cpu_hold),  32'd0);
        check_eq("two_fe",     32'(fe_cnt), 32'd0);

        // Junk byte then an empty image, starting from DONE
        clear_counts();
        send_byte(8'h55, 1'b1);
        check_eq("junk_done_kept", 32'(bus.load_done), 32'd1);
        send_byte(8'hA5, 1'b1);
        check_eq("resync_hold", 32'(bus.cpu_hold),  32'd1);
        check_eq("resync_done", 32'(bus.load_done), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check_eq("empty_bytes",  32'(bv_cnt), 32'd4);
        check_eq("empty_wr_cnt", 32'(wr_cnt), 32'd0);
        check_eq("empty_done",   32'(bus.load_done), 32'd1);
        check_eq("empty_fe",     32'(fe_cnt), 32'd0);

        // Length 17 exceeds a 16-word memory
        clear_counts();
        seq = '{8'hA5, 8'h11, 8'h00};
        send_seq(seq);
        check_eq("ovf_fe",     32'(fe_cnt), 32'd1);
        check_eq("ovf_state",  32'(dut.state_q), 32'(IDLE));
        check_eq("ovf_hold",   32'(bus.cpu_hold), 32'd1);
        check_eq("ovf_wr_cnt", 32'(wr_cnt), 32'd0);

        // Length 16 is exactly full and accepted
        clear_counts();
        seq = '{8'hA5, 8'h10, 8'h00};
        send_seq(seq);
        for (int k = 0; k < 16; k++) begin
            w = {8'(k), 8'hC3, 8'(k) ^ 8'h5A, 8'h3C};
            send_byte(w[7:0], 1'b1);
            send_byte(w[15:8], 1'b1);
            send_byte(w[23:16], 1'b1);
            send_byte(w[31:24], 1'b1);
        end
        check_eq("full_wr_cnt", 32'(wr_cnt), 32'd16);
        for (int k = 0; k < 16; k++) begin
            w = {8'(k), 8'hC3, 8'(k) ^ 8'h5A, 8'h3C};
            check_eq($sformatf("full_addr%0d", k), wr_addr[k], 32'(k));
            check_eq($sformatf("full_data%0d", k), wr_data[k], w);
        end
        check_eq("full_done", 32'(bus.load_done), 32'd1);
        check_eq("full_fe",   32'(fe_cnt), 32'd0);

        // Bad stop bit mid-word, then a clean retry
        clear_counts();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(seq);
        send_byte(8'h00, 1'b0);
        check_eq("stop_fe",     32'(fe_cnt), 32'd1);
        check_eq("stop_wr_cnt", 32'(wr_cnt), 32'd0);
        check_eq("stop_state",  32'(dut.state_q), 32'(IDLE));
        clear_counts();
        seq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq);
        check_eq("retry_wr_cnt", 32'(wr_cnt), 32'd1);
        check_eq("retry_addr",   wr_addr[0], 32'd0);
        check_eq("retry_data",   wr_data[0], 32'hDEAD_BEEF);
        check_eq("retry_done",   32'(bus.load_done), 32'd1);

        // Short low glitch while idle
        clear_counts();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check_eq("glitch_bv", 32'(bv_cnt), 32'd0);
        check_eq("glitch_fe", 32'(fe_cnt), 32'd0);

        // Reset during the third data byte, then a full frame
        seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(seq);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("mid_rst_done", 32'(bus.load_done), 32'd0);
        check_eq("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        rst = 1'b1;
        clear_counts();
        repeat (12 * CPB) @(negedge clk);
        check_eq("mid_rst_nowr", 32'(wr_cnt), 32'd0);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_seq(seq);
        check_eq("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);
        check_eq("post_rst_addr",   wr_addr[0], 32'd0);
        check_eq("post_rst_data",   wr_data[0], 32'h1234_5678);
        check_eq("post_rst_done",   32'(bus.load_done), 32'd1);
        check_eq("post_rst_hold",   32'(bus.cpu_hold),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
